// File: rtl/dpll_trail_pkg.sv
// Shared types for the DPLL assignment trail: literal and trail-entry records
// plus the FSM state encoding used by dpll_trail.
package common;

    localparam int VAR_W   = 8;
    localparam int ENTRY_W = VAR_W + 3;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        DONE
    } trail_state_t;

    typedef struct packed {
        logic [VAR_W-1:0] vidx;
        logic             val;
    } lit_t;

    // A literal as stored on the trail, extended with its decision/flip history.
    typedef struct packed {
        logic [VAR_W-1:0] vidx;
        logic             val;
        logic             dec;
        logic             flipped;
    } trail_entry_t;

    localparam trail_entry_t zero_trail_entry = '0;

endpackage

// File: rtl/dpll_trail_stack.sv
// LIFO storage for trail entries with push, pop, in-place replace of the top
// entry and a combinational view of the current top.
module Stack_trail
    import common::*;
#(
    parameter int  DEPTH = 16,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] push_entry_i,
    input  logic               pop_i,
    input  logic               replace_i,
    input  logic [ENTRY_W-1:0] replace_entry_i,
    output logic [ENTRY_W-1:0] front_o,
    output logic [DW-1:0]      count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [DW-1:0]      count_q;
    logic [AW-1:0]      top_idx;
    logic [AW-1:0]      push_idx;
    logic               not_full;
    logic               not_empty;

    assign top_idx   = AW'(count_q - DW'(1));
    assign push_idx  = AW'(count_q);
    assign not_full  = (count_q != DW'(DEPTH));
    assign not_empty = (count_q != '0);

    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            count_q <= '0;
        end else if (push_i && not_full) begin
            count_q <= count_q + DW'(1);
        end else if (pop_i && not_empty) begin
            count_q <= count_q - DW'(1);
        end
    end

    // Entry storage carries no reset; the count alone defines which slots are live.
    always_ff @(posedge clock) begin
        if (push_i && not_full) begin
            mem_q[push_idx] <= push_entry_i;
        end else if (replace_i && not_empty) begin
            mem_q[top_idx] <= replace_entry_i;
        end
    end

    assign front_o = not_empty ? mem_q[top_idx] : zero_trail_entry;
    assign count_o = count_q;

endmodule

// File: rtl/dpll_trail.sv
// DPLL assignment trail: records pushed literals, tracks the partial model and
// performs chronological backtracking by flipping the most recent open decision.
module dpll_trail
    import common::*;
#(
    parameter int  NUM_VARS = 16,
    parameter int  DEPTH    = NUM_VARS,
    parameter int  CNT_W    = 16,
    localparam int VW       = $clog2(NUM_VARS + 1),
    localparam int DW       = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                push,
    input  logic [VW-1:0]       push_var,
    input  logic                push_val,
    input  logic                push_dec,
    input  logic                backtrack,
    output logic                busy,
    output logic                bt_done,
    output logic                bt_found,
    output logic [VW-1:0]       bt_var,
    output logic                bt_val,
    output logic                unsat,
    output logic                full,
    output logic                err,
    output logic [DW-1:0]       depth,
    output logic [DW-1:0]       level,
    output logic [NUM_VARS-1:0] assigned,
    output logic [NUM_VARS-1:0] model,
    output logic [CNT_W-1:0]    conflicts
);

    trail_state_t         state_q;
    logic                 busy_q;
    logic                 bt_done_q;
    logic                 bt_found_q;
    logic [VW-1:0]        bt_var_q;
    logic                 bt_val_q;
    logic                 unsat_q;
    logic                 err_q;
    logic [DW-1:0]        level_q;
    logic [NUM_VARS-1:0]  assigned_q;
    logic [NUM_VARS-1:0]  model_q;
    logic [CNT_W-1:0]     conflicts_q;

    logic [DW-1:0]        depth_w;
    logic [ENTRY_W-1:0]   front_raw;
    trail_entry_t         front;
    trail_entry_t         push_entry;
    trail_entry_t         replace_entry;
    logic [NUM_VARS-1:0]  push_mask;
    logic [NUM_VARS-1:0]  front_mask;
    logic                 push_legal;
    logic                 st_pop;
    logic                 st_replace;
    logic                 trail_empty;

    assign front       = trail_entry_t'(front_raw);
    assign trail_empty = (depth_w == '0);
    assign full        = (depth_w == DW'(DEPTH));

    assign push_mask  = NUM_VARS'(1) << (push_var - VW'(1));
    assign front_mask = NUM_VARS'(1) << (VW'(front.vidx) - VW'(1));

    assign push_entry    = '{vidx: VAR_W'(push_var), val: push_val, dec: push_dec, flipped: 1'b0};
    assign replace_entry = '{vidx: front.vidx, val: ~front.val, dec: 1'b0, flipped: 1'b1};

    // A push is only taken in IDLE when it does not collide with a backtrack request.
    always_comb begin
        push_legal = push && (state_q == IDLE) && !backtrack && !full
                     && (push_var != '0) && (push_var <= VW'(NUM_VARS))
                     && ((assigned_q & push_mask) == '0);
        st_pop     = 1'b0;
        st_replace = 1'b0;
        if (state_q == POP && !trail_empty) begin
            if (front.dec && !front.flipped) begin
                st_replace = 1'b1;
            end else begin
                st_pop = 1'b1;
            end
        end
    end

    Stack_trail #(
        .DEPTH(DEPTH)
    ) u_stack (
        .clock          (clock),
        .reset          (reset),
        .clear_i        (clear),
        .push_i         (push_legal),
        .push_entry_i   (push_entry),
        .pop_i          (st_pop),
        .replace_i      (st_replace),
        .replace_entry_i(replace_entry),
        .front_o        (front_raw),
        .count_o        (depth_w)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            bt_done_q   <= 1'b0;
            bt_found_q  <= 1'b0;
            bt_var_q    <= '0;
            bt_val_q    <= 1'b0;
            unsat_q     <= 1'b0;
            err_q       <= 1'b0;
            level_q     <= '0;
            assigned_q  <= '0;
            model_q     <= '0;
            conflicts_q <= '0;
        end else if (clear) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            bt_done_q   <= 1'b0;
            unsat_q     <= 1'b0;
            err_q       <= 1'b0;
            level_q     <= '0;
            assigned_q  <= '0;
            model_q     <= '0;
            conflicts_q <= '0;
        end else begin
            bt_done_q <= 1'b0;
            if (push && !push_legal) begin
                err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (push_legal) begin
                        assigned_q <= assigned_q | push_mask;
                        model_q    <= push_val ? (model_q | push_mask) : (model_q & ~push_mask);
                        if (push_dec) begin
                            level_q <= level_q + DW'(1);
                        end
                    end
                    if (backtrack) begin
                        if (conflicts_q != '1) begin
                            conflicts_q <= conflicts_q + CNT_W'(1);
                        end
                        busy_q  <= 1'b1;
                        state_q <= POP;
                    end
                end
                POP: begin
                    if (backtrack) begin
                        err_q <= 1'b1;
                    end
                    if (trail_empty) begin
                        bt_found_q <= 1'b0;
                        bt_var_q   <= '0;
                        bt_val_q   <= 1'b0;
                        unsat_q    <= 1'b1;
                        state_q    <= DONE;
                    end else if (st_replace) begin
                        model_q    <= front.val ? (model_q & ~front_mask) : (model_q | front_mask);
                        level_q    <= level_q - DW'(1);
                        bt_found_q <= 1'b1;
                        bt_var_q   <= VW'(front.vidx);
                        bt_val_q   <= ~front.val;
                        state_q    <= DONE;
                    end else begin
                        assigned_q <= assigned_q & ~front_mask;
                    end
                end
                DONE: begin
                    if (backtrack) begin
                        err_q <= 1'b1;
                    end
                    bt_done_q <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign bt_done   = bt_done_q;
    assign bt_found  = bt_found_q;
    assign bt_var    = bt_var_q;
    assign bt_val    = bt_val_q;
    assign unsat     = unsat_q;
    assign err       = err_q;
    assign depth     = depth_w;
    assign level     = level_q;
    assign assigned  = assigned_q;
    assign model     = model_q;
    assign conflicts = conflicts_q;

endmodule

// File: tb/tb_dpll_trail.sv
// Directed bench for dpll_trail: push/backtrack walkthrough, illegal requests,
// counter saturation, clear and reset during a backtrack.
module tb_dpll_trail;

    localparam int NUM_VARS = 16;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 2;
    localparam int VW       = $clog2(NUM_VARS + 1);
    localparam int DW       = $clog2(DEPTH + 1);

    logic                clock = 1'b0;
    logic                reset;
    logic                clear;
    logic                push;
    logic [VW-1:0]       push_var;
    logic                push_val;
    logic                push_dec;
    logic                backtrack;
    logic                busy;
    logic                bt_done;
    logic                bt_found;
    logic [VW-1:0]       bt_var;
    logic                bt_val;
    logic                unsat;
    logic                full;
    logic                err;
    logic [DW-1:0]       depth;
    logic [DW-1:0]       level;
    logic [NUM_VARS-1:0] assigned;
    logic [NUM_VARS-1:0] model;
    logic [CNT_W-1:0]    conflicts;

    int compared   = 0;
    int mismatched = 0;

    dpll_trail #(
        .NUM_VARS(NUM_VARS),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .push     (push),
        .push_var (push_var),
        .push_val (push_val),
        .push_dec (push_dec),
        .backtrack(backtrack),
        .busy     (busy),
        .bt_done  (bt_done),
        .bt_found (bt_found),
        .bt_var   (bt_var),
        .bt_val   (bt_val),
        .unsat    (unsat),
        .full     (full),
        .err      (err),
        .depth    (depth),
        .level    (level),
        .assigned (assigned),
        .model    (model),
        .conflicts(conflicts)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drives one cycle of requests, lets the edge consume them, then drops the strobes.
    task automatic applyStimulus(input logic p, input logic [VW-1:0] v, input logic pv,
                                 input logic pd, input logic bt, input logic clr);
        push      = p;
        push_var  = v;
        push_val  = pv;
        push_dec  = pd;
        backtrack = bt;
        clear     = clr;
        tick();
        push      = 1'b0;
        backtrack = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called right after the request edge; lat counts cycles from the request cycle.
    task automatic waitDone(input string tag, input int expLat, input logic checkLat);
        int lat = 1;
        while (bt_done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput({tag, "_done"}, 32'(bt_done), 32'd1);
        if (checkLat) begin
            checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
        end
    endtask

    initial begin
        logic sawDone;
        reset     = 1'b1;
        clear     = 1'b0;
        push      = 1'b0;
        push_var  = '0;
        push_val  = 1'b0;
        push_dec  = 1'b0;
        backtrack = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst_depth", 32'(depth), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_assigned", 32'(assigned), 32'h0);
        checkOutput("rst_model", 32'(model), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_bt_done", 32'(bt_done), 32'd0);
        checkOutput("rst_flags", {29'd0, err, unsat, full}, 32'd0);
        checkOutput("rst_conflicts", 32'(conflicts), 32'd0);

        applyStimulus(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("push_depth", 32'(depth), 32'd4);
        checkOutput("push_level", 32'(level), 32'd2);
        checkOutput("push_assigned", 32'(assigned), 32'h0056);
        checkOutput("push_model", 32'(model), 32'h0046);
        checkOutput("push_full", 32'(full), 32'd1);
        checkOutput("push_err", 32'(err), 32'd0);

        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("bt1_busy", 32'(busy), 32'd1);
        waitDone("bt1", 4, 1'b1);
        checkOutput("bt1_found", 32'(bt_found), 32'd1);
        checkOutput("bt1_var", 32'(bt_var), 32'd2);
        checkOutput("bt1_val", 32'(bt_val), 32'd0);
        checkOutput("bt1_depth", 32'(depth), 32'd3);
        checkOutput("bt1_level", 32'(level), 32'd1);
        checkOutput("bt1_model", 32'(model), 32'h0044);
        checkOutput("bt1_assigned", 32'(assigned), 32'h0016);
        checkOutput("bt1_conflicts", 32'(conflicts), 32'd1);
        checkOutput("bt1_busy_end", 32'(busy), 32'd0);
        tick();
        checkOutput("bt1_pulse", 32'(bt_done), 32'd0);
        checkOutput("bt1_hold", {30'd0, bt_found, bt_val}, 32'h2);

        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        waitDone("bt2", 5, 1'b1);
        checkOutput("bt2_found", 32'(bt_found), 32'd1);
        checkOutput("bt2_var", 32'(bt_var), 32'd3);
        checkOutput("bt2_val", 32'(bt_val), 32'd0);
        checkOutput("bt2_depth", 32'(depth), 32'd1);
        checkOutput("bt2_level", 32'(level), 32'd0);
        checkOutput("bt2_assigned", 32'(assigned), 32'h0004);
        checkOutput("bt2_model", 32'(model), 32'h0040);
        checkOutput("bt2_conflicts", 32'(conflicts), 32'd2);

        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        waitDone("bt3", 0, 1'b0);
        checkOutput("bt3_found", 32'(bt_found), 32'd0);
        checkOutput("bt3_unsat", 32'(unsat), 32'd1);
        checkOutput("bt3_depth", 32'(depth), 32'd0);
        checkOutput("bt3_assigned", 32'(assigned), 32'h0);
        checkOutput("bt3_conflicts", 32'(conflicts), 32'd3);

        // Empty-trail backtrack, a second request while busy, and counter saturation.
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        waitDone("bt4", 0, 1'b0);
        checkOutput("bt4_found", 32'(bt_found), 32'd0);
        checkOutput("bt4_unsat", 32'(unsat), 32'd1);
        checkOutput("bt4_err_busy", 32'(err), 32'd1);
        checkOutput("bt4_conflicts_sat", 32'(conflicts), 32'd3);

        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_depth", 32'(depth), 32'd0);
        checkOutput("clr_level", 32'(level), 32'd0);
        checkOutput("clr_assigned", 32'(assigned), 32'h0);
        checkOutput("clr_model", 32'(model), 32'h0);
        checkOutput("clr_flags", {29'd0, err, unsat, full}, 32'd0);
        checkOutput("clr_conflicts", 32'(conflicts), 32'd0);
        checkOutput("clr_bt", {25'd0, busy, bt_done, bt_found, bt_var, bt_val}, 32'd0);

        applyStimulus(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("var0_err", 32'(err), 32'd1);
        checkOutput("var0_state", {depth, assigned, model}, {DW'(1), 16'h0004, 16'h0004});

        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd17, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("var17_err", 32'(err), 32'd1);
        checkOutput("var17_state", {depth, assigned, model}, {DW'(1), 16'h0004, 16'h0004});

        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("dup_err", 32'(err), 32'd1);
        checkOutput("dup_state", {depth, assigned, model}, {DW'(1), 16'h0004, 16'h0004});

        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("fill_full", 32'(full), 32'd1);
        checkOutput("fill_err", 32'(err), 32'd0);
        applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("full_err", 32'(err), 32'd1);
        checkOutput("full_state", {depth, assigned, model}, {DW'(4), 16'h000F, 16'h0005});

        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("coinc_err", 32'(err), 32'd1);
        checkOutput("coinc_busy", 32'(busy), 32'd1);
        checkOutput("coinc_state", {depth, assigned, model}, {DW'(1), 16'h0004, 16'h0004});
        waitDone("coinc", 3, 1'b1);
        checkOutput("coinc_flip", {26'd0, bt_found, bt_var}, {26'd0, 1'b1, 5'd3});

        // Reset lands while POP is still draining implied entries.
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("midpop_depth", 32'(depth), 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_depth", 32'(depth), 32'd0);
        sawDone = bt_done;
        for (int i = 0; i < 6; i++) begin
            tick();
            sawDone = sawDone | bt_done;
        end
        checkOutput("midrst_no_done", 32'(sawDone), 32'd0);
        applyStimulus(1'b1, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("midrst_push", {depth, assigned, model}, {DW'(1), 16'h8000, 16'h8000});
        checkOutput("midrst_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dpll_trail.md
DPLL_TRAIL -- requirements
Module: dpll_trail

Interface
REQ-001 Parameter NUM_VARS, default 16: number of Boolean variables; legal variable indices are 1..NUM_VARS, and index 0 is invalid.
REQ-002 Parameter DEPTH, default NUM_VARS: trail capacity in entries.
REQ-003 Parameter CNT_W, default 16: width of the conflict counter.
REQ-004 Localparams VW = $clog2(NUM_VARS+1) and DW = $clog2(DEPTH+1).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous empty of the trail.
- push  in  1  append one literal.
- push_var  in  VW  variable index.
- push_val  in  1  polarity.
- push_dec  in  1  1 = decision literal, 0 = implied literal.
- backtrack  in  1  request chronological backtrack.
- busy  out  1  backtrack in progress.
- bt_done  out  1  one-cycle pulse at backtrack end.
- bt_found  out  1  a decision was flipped.
- bt_var  out  VW  flipped literal index.
- bt_val  out  1  flipped literal polarity.
- unsat  out  1  sticky: no decision left.
- full  out  1  depth == DEPTH.
- err  out  1  sticky: illegal request.
- depth  out  DW  entries on the trail.
- level  out  DW  unflipped decisions on the trail.
- assigned  out  NUM_VARS  per-variable assigned flag.
- model  out  NUM_VARS  per-variable value; bit v-1 holds variable v.
- conflicts  out  CNT_W  accepted backtracks, saturating.

Function
REQ-007 FSM states: IDLE, POP, DONE.
REQ-008 Legal push, in IDLE only: 1 <= push_var <= NUM_VARS, assigned[push_var-1] = 0, and full = 0. On the next edge:
- append the entry {var, val, dec, flipped=0};
- assigned[var-1] = 1 and model[var-1] = val;
- depth increments, and level increments if dec = 1.
REQ-009 Illegal push (bad index, already assigned, full, busy, or coincident with backtrack) SHALL be ignored, with err set to 1.
REQ-010 backtrack in IDLE: conflicts increments (saturating at all-ones), busy = 1, and the FSM goes to POP. Backtrack while busy SHALL be ignored, with err set.
REQ-011 POP pops one top entry per cycle.
- Popping clears assigned[var-1] and leaves model unchanged.
- Popped entry with dec = 1 and flipped = 0: the FSM SHALL instead, in the same cycle, replace that entry in place with {var, ~val, dec=0, flipped=1}. It sets assigned, sets model to ~val, sets level -= 1, loads bt_var/bt_val, sets bt_found = 1, and goes to DONE.
- Any other entry: depth -= 1, and the FSM stays in POP.
- Empty trail in POP: bt_found = 0, unsat = 1, go to DONE.
REQ-012 DONE: bt_done = 1 for exactly one cycle, busy = 0, then the FSM returns to IDLE. Backtrack latency is k+2 cycles from request to bt_done, where k is the number of entries popped.
REQ-013 bt_found/bt_var/bt_val SHALL hold until the next bt_done.
REQ-014 Backtrack on an empty trail SHALL reach DONE with bt_found = 0 and unsat = 1.
REQ-015 clear SHALL have priority over push and backtrack in any state. In one cycle it sets:
- depth = 0 and level = 0;
- assigned = 0, model = 0;
- err = 0, unsat = 0, conflicts = 0;
- FSM to IDLE.
REQ-016 full SHALL be combinational from depth. Push at depth == DEPTH is ignored with err set, and the trail is not modified.

Reset
REQ-017 Reset SHALL have priority over clear and SHALL produce the same state as clear, plus bt_found = 0, bt_var = 0, bt_val = 0, bt_done = 0, busy = 0.

Structure
REQ-018 Package common SHALL hold typedef trail_entry_t {var index, val, dec, flipped}, extending the existing lit fields, plus its zero constant zero_trail_entry.
REQ-019 The trail storage SHALL be one sub-module, Stack_trail: a parametrised DEPTH-entry LIFO with push, pop, replace-top and a combinational front. Pop and replace-top in the same cycle are not required.

Verification
REQ-020 Reset; push (3,1,dec), (5,0,imp), (2,1,dec), (7,1,imp) -> depth = 4, level = 2, assigned = 0x0056, model bits 2/6 = 1 (vars 3/7), bit 1 = 1 (var 2), bit 4 = 0 (var 5).
REQ-021 Then backtrack -> bt_done 4 cycles after request (k = 2). Expected state:
- bt_found = 1, bt_var = 2, bt_val = 0;
- depth = 3, level = 1, model bit 1 = 0;
- assigned bit 6 = 0, conflicts = 1.
REQ-022 Second backtrack -> flipped var 2 is popped through and var 3 is flipped: bt_var = 3, bt_val = 0, depth = 1, level = 0.
REQ-023 Third backtrack -> trail empties, bt_found = 0, unsat = 1, conflicts = 3. Then clear -> all outputs are back at reset values.
REQ-024 Illegal-request checks: push var 0; push an assigned var; push with DEPTH = 4 when full; push in the same cycle as backtrack. Each -> err = 1, and depth, assigned and model are unchanged.
REQ-025 Reset asserted mid-POP -> next cycle busy = 0, depth = 0, bt_done is never pulsed, and a subsequent push is accepted.
